// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: FSM state
// encoding and the counter-width helper.
package serial_cmp_pkg;

  // Encoding 2'd3 is unused; the FSM treats it as illegal and returns to IDLE.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Smallest r with 2**r >= n; sizes a counter that must hold n-1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// One-bit MSB-first comparison step: the first differing bit pair decides the
// result, and later bit pairs cannot change a decided result.
module cmp_bit_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic decided_in,
  input  logic gt_in,
  input  logic lt_in,
  output logic decided_out,
  output logic gt_out,
  output logic lt_out
);

  assign decided_out = decided_in | (a_bit ^ b_bit);
  assign gt_out      = decided_in ? gt_in : (a_bit & ~b_bit);
  assign lt_out      = decided_in ? lt_in : (~a_bit & b_bit);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial, MSB-first unsigned comparator. Each comparison takes WIDTH bit
// cycles, with no early exit. Results are held until the next done pulse.
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int CNT_W = clog2(WIDTH);

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb;
  logic [CNT_W-1:0] cnt;
  logic             decided, pgt, plt;
  logic             cell_decided, cell_gt, cell_lt;

  cmp_bit_cell u_cell (
    .a_bit       (sa[WIDTH-1]),
    .b_bit       (sb[WIDTH-1]),
    .decided_in  (decided),
    .gt_in       (pgt),
    .lt_in       (plt),
    .decided_out (cell_decided),
    .gt_out      (cell_gt),
    .lt_out      (cell_lt)
  );

  // NOTE: next-state defaults to the current state before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_SHIFT;
      S_SHIFT: if (cnt == '0) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != S_IDLE);
    end
  end

  // NOTE: the operand shift registers are reset along with everything else so a reset leaves no stale operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa      <= '0;
      sb      <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      pgt     <= 1'b0;
      plt     <= 1'b0;
      done    <= 1'b0;
      gt      <= 1'b0;
      lt      <= 1'b0;
      eq      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sa      <= a;
            sb      <= b;
            cnt     <= CNT_W'(WIDTH - 1);
            decided <= 1'b0;
            pgt     <= 1'b0;
            plt     <= 1'b0;
          end
        end
        S_SHIFT: begin
          decided <= cell_decided;
          pgt     <= cell_gt;
          plt     <= cell_lt;
          sa      <= {sa[WIDTH-2:0], 1'b0};
          sb      <= {sb[WIDTH-2:0], 1'b0};
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        S_DONE: begin
          gt   <= pgt;
          lt   <= plt;
          eq   <= ~pgt & ~plt;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench: an 8-bit instance for directed and random compares, and
// a 2-bit instance swept over every operand pair.
module tb_serial_magnitude_comparator;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, gt8, lt8, eq8;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, gt2, lt2, eq2;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] last8 = 3'b000;  // expected {gt,lt,eq} of the 8-bit instance
  logic [2:0] last2 = 3'b000;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .gt(gt8), .lt(lt8), .eq(eq8)
  );

  serial_magnitude_comparator #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .gt(gt2), .lt(lt2), .eq(eq2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: unsigned magnitude relation as {gt, lt, eq}.
  function automatic logic [2:0] ref_cmp(input int unsigned x, input int unsigned y);
    return {x > y, x < y, x == y};
  endfunction

  // One 8-bit compare; optionally pokes start with other operands mid-shift.
  task automatic run8(input logic [7:0] x, input logic [7:0] y, input bit poke, input string tag);
    int cyc, busy_low, extra;
    @(negedge clk);
    start8 = 1'b1; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    check({tag, " busy after accept"}, busy8, 1);
    check({tag, " result held at start"}, {gt8, lt8, eq8}, last8);
    cyc = 0; busy_low = 0;
    while (!done8 && cyc < 40) begin
      if (!busy8) busy_low++;
      if (poke && cyc == 2) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; end
      if (poke && cyc == 5) start8 = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, cyc, 9);
    check({tag, " busy through shift"}, busy_low, 0);
    check({tag, " busy at done"}, busy8, 0);
    last8 = ref_cmp(x, y);
    check({tag, " result"}, {gt8, lt8, eq8}, last8);
    @(negedge clk);
    check({tag, " done one cycle"}, done8, 0);
    if (poke) begin
      extra = 0;
      repeat (12) begin @(negedge clk); if (done8) extra++; end
      check({tag, " no extra done"}, extra, 0);
    end
  endtask

  task automatic run2(input logic [1:0] x, input logic [1:0] y);
    int cyc;
    @(negedge clk);
    start2 = 1'b1; a2 = x; b2 = y;
    @(negedge clk);
    start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
    check("w2 result held at start", {gt2, lt2, eq2}, last2);
    cyc = 0;
    while (!done2 && cyc < 20) begin @(negedge clk); cyc++; end
    check("w2 latency", cyc, 3);
    last2 = ref_cmp(x, y);
    check("w2 result", {gt2, lt2, eq2}, last2);
  endtask

  task automatic reset_mid_op();
    int dones;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h3C; b8 = 8'hA5;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid reset outputs", {busy8, done8, gt8, lt8, eq8}, 5'b0);
    last8 = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin @(negedge clk); if (done8) dones++; end
    check("mid reset no done", dones, 0);
    run8(8'h01, 8'h00, 1'b0, "after reset");
  endtask

  task automatic back_to_back();
    logic [2:0] expq[$];
    int cyc, accepts, dones, last_acc;
    logic prev_busy;
    cyc = 0; accepts = 0; dones = 0; last_acc = 0;
    prev_busy = busy8;
    a8 = 8'($urandom); b8 = 8'($urandom);
    start8 = 1'b1;
    while (dones < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy8 && !prev_busy) begin
        accepts++;
        if (accepts > 1) check("b2b spacing", cyc - last_acc, 10);
        check("b2b held at accept", {gt8, lt8, eq8}, last8);
        last_acc = cyc;
        expq.push_back(ref_cmp(a8, b8));
        a8 = 8'($urandom); b8 = 8'($urandom);
        if (accepts == 4) start8 = 1'b0;
      end
      if (done8) begin
        dones++;
        if (expq.size() > 0) last8 = expq.pop_front();
        check("b2b result", {gt8, lt8, eq8}, last8);
      end
      prev_busy = busy8;
    end
    check("b2b accepts", accepts, 4);
    check("b2b dones", dones, 4);
    start8 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] x, y;
    repeat (3) @(negedge clk);
    check("reset state w8", {busy8, done8, gt8, lt8, eq8}, 5'b0);
    check("reset state w2", {busy2, done2, gt2, lt2, eq2}, 5'b0);
    rst_n = 1'b1;

    run8(8'hA5, 8'h3C, 1'b0, "A5 vs 3C");
    run8(8'h80, 8'h81, 1'b0, "80 vs 81");
    run8(8'hFF, 8'hFF, 1'b0, "FF vs FF");
    run8(8'h10, 8'h20, 1'b1, "start while busy");
    reset_mid_op();
    back_to_back();

    for (int i = 0; i < 24; i++) begin
      x = 8'($urandom);
      y = (i % 4 == 0) ? x : 8'($urandom);
      run8(x, y, 1'b0, "random");
    end

    for (int i = 0; i < 16; i++) run2(2'(i >> 2), 2'(i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
